// File: rtl/text_console_pkg.sv
// text_console_pkg: shared defaults, control codes and
// the state encoding used by text_console and its mover.
package text_console_pkg;
  localparam logic [17:0] DEF_BASE = 18'h0F000;
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 25;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    PUT_CHAR,
    PUT_ATTR,
    SCR_RD,
    SCR_WAIT,
    SCR_WR,
    FILL_CHR,
    FILL_ATR
  } state_t;
endpackage

// File: rtl/text_console_mover.sv
// text_console_mover: scroll copy and space/attr fill engine.
// Scroll copy exists only with TEXT_CONSOLE_SCROLL_EN defined.
module text_console_mover
  import text_console_pkg::*;
#(
  parameter logic [17:0] BASE = DEF_BASE,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        scroll,
  input  logic [7:0]  attr,
  input  logic [7:0]  rdata,
  output logic        done,
  output logic [17:0] address,
  output logic [7:0]  wdata,
  output logic        we
);
  localparam int CELLS = COLS * ROWS;
  localparam logic [12:0] CELL_LAST = 13'(CELLS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [12:0] COPY_LAST = 13'(2 * (CELLS - COLS) - 1);
  localparam logic [12:0] ROW_LAST = 13'(CELLS - COLS);
  localparam logic [17:0] SRC = BASE + 18'(2 * COLS);
  logic [17:0] cnt_b;
`else
  wire scroll_unused = scroll ^ (^rdata);
`endif

  state_t state, state_nxt;
  logic [12:0] cnt, cnt_nxt;
  logic [17:0] cell_b;

  // cnt is a byte index while copying, a cell index while filling
  assign cell_b = {4'b0, cnt, 1'b0};
`ifdef TEXT_CONSOLE_SCROLL_EN
  assign cnt_b = {5'b0, cnt};
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    address = '0;
    wdata = '0;
    we = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt = '0;
`ifdef TEXT_CONSOLE_SCROLL_EN
          state_nxt = scroll ? SCR_RD : FILL_CHR;
`else
          state_nxt = FILL_CHR;
`endif
        end
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: begin
        address = SRC + cnt_b;
        state_nxt = SCR_WAIT;
      end
      SCR_WAIT: begin
        address = SRC + cnt_b;
        state_nxt = SCR_WR;
      end
      SCR_WR: begin
        address = BASE + cnt_b;
        wdata = rdata;
        we = 1'b1;
        if (cnt == COPY_LAST) begin
          state_nxt = FILL_CHR;
          cnt_nxt = ROW_LAST;
        end else begin
          state_nxt = SCR_RD;
          cnt_nxt = cnt + 13'd1;
        end
      end
`endif
      FILL_CHR: begin
        address = BASE + cell_b;
        wdata = CH_SP;
        we = 1'b1;
        state_nxt = FILL_ATR;
      end
      FILL_ATR: begin
        address = BASE + cell_b + 18'd1;
        wdata = attr;
        we = 1'b1;
        if (cnt == CELL_LAST) begin
          state_nxt = IDLE;
          done = 1'b1;
        end else begin
          state_nxt = FILL_CHR;
          cnt_nxt = cnt + 13'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/text_console.sv
// text_console: CPU byte stream to video RAM text cells.
// Define TEXT_CONSOLE_SCROLL_EN to scroll instead of wrap.
module text_console
  import text_console_pkg::*;
#(
  parameter logic [17:0] BASE = DEF_BASE,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  output logic        in_ready,
  output logic [17:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [10:0] cursor
);
  localparam int CELLS = COLS * ROWS;
  localparam logic [10:0] COLS_C = 11'(COLS);
  localparam logic [10:0] LAST = 11'(CELLS - 1);
  localparam logic [11:0] CELLS_W = 12'(CELLS);
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [10:0] ROW_LAST = 11'(CELLS - COLS);
`endif

  state_t state, state_nxt;
  logic [10:0] cur, cur_nxt;
  logic [7:0] char_q, attr_q;
  logic accept;
  logic mv_start, mv_scroll, mv_done, mv_we;
  logic [17:0] mv_address;
  logic [7:0] mv_wdata;
  logic [11:0] lf_sum;
  logic [17:0] cell_addr;

  assign in_ready = reset_n && (state == IDLE);
  assign accept = in_valid && in_ready;
  assign lf_sum = {1'b0, cur} + {1'b0, COLS_C};
  assign cell_addr = BASE + {6'b0, cur, 1'b0};
  assign cursor = cur;

  text_console_mover #(
    .BASE(BASE),
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_mover (
    .clock(clock),
    .reset_n(reset_n),
    .start(mv_start),
    .scroll(mv_scroll),
    .attr(attr_q),
    .rdata(mem_rdata),
    .done(mv_done),
    .address(mv_address),
    .wdata(mv_wdata),
    .we(mv_we)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cur <= '0;
      char_q <= '0;
      attr_q <= '0;
    end else begin
      state <= state_nxt;
      cur <= cur_nxt;
      if (accept) begin
        char_q <= in_data;
        attr_q <= in_attr;
      end
    end
  end

  // SCR_RD / FILL_CHR here mean "mover busy" until it reports done
  always_comb begin
    state_nxt = state;
    cur_nxt = cur;
    mv_start = 1'b0;
    mv_scroll = 1'b0;
    mem_address = mv_address;
    mem_wdata = mv_wdata;
    mem_we = mv_we;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (in_data >= CH_SP): state_nxt = PUT_CHAR;
            (in_data == CH_CR): cur_nxt = cur - (cur % COLS_C);
            (in_data == CH_LF): begin
              if (lf_sum >= CELLS_W) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                mv_start = 1'b1;
                mv_scroll = 1'b1;
                state_nxt = SCR_RD;
`else
                cur_nxt = 11'(lf_sum - CELLS_W);
`endif
              end else begin
                cur_nxt = lf_sum[10:0];
              end
            end
            (in_data == CH_BS): begin
              if (cur != '0) cur_nxt = cur - 11'd1;
            end
            (in_data == CH_FF): begin
              mv_start = 1'b1;
              state_nxt = FILL_CHR;
            end
            default: ;
          endcase
        end
      end
      PUT_CHAR: begin
        mem_address = cell_addr;
        mem_wdata = char_q;
        mem_we = 1'b1;
        state_nxt = PUT_ATTR;
      end
      PUT_ATTR: begin
        mem_address = cell_addr + 18'd1;
        mem_wdata = attr_q;
        mem_we = 1'b1;
        state_nxt = IDLE;
        if (cur == LAST) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
          mv_start = 1'b1;
          mv_scroll = 1'b1;
          state_nxt = SCR_RD;
          cur_nxt = ROW_LAST;
`else
          cur_nxt = '0;
`endif
        end else begin
          cur_nxt = cur + 11'd1;
        end
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: begin
        if (mv_done) state_nxt = IDLE;
      end
`endif
      FILL_CHR: begin
        if (mv_done) begin
          state_nxt = IDLE;
          cur_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
